// File: rtl/lfsr_checker.sv
// Checker for a 4-bit x^4+x+1 LFSR stream.
// It searches for SYNC_LEN consecutive correct predictions to lock, then flywheels and counts errors.
module lfsr_checker #(
  parameter int SYNC_LEN = 3,
  parameter int LOSS_LEN = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [3:0] data_i,
  input  logic       clear_i,
  output logic       locked_o,
  output logic       err_o,
  output logic [7:0] err_cnt_o
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] SYNC_LEN_W = 4'(SYNC_LEN);
  localparam logic [3:0] LOSS_LEN_W = 4'(LOSS_LEN);

  // The all-zero state is illegal for the generator, so it is remapped to 1001.
  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    logic [3:0] n;
    n = {v[2:0], v[3] ^ v[0]};
    return (n == 4'b0000) ? 4'b1001 : n;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] ref_q, ref_d;
  logic       has_ref_q, has_ref_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       locked_d, err_d;
  logic [7:0] err_cnt_d;

  logic [3:0] pred;
  logic       hit;
  logic [3:0] match_inc, miss_inc;

  assign pred      = lfsr_next(ref_q);
  assign hit       = has_ref_q && (data_i != 4'b0000) && (data_i == pred);
  assign match_inc = match_cnt_q + 4'd1;
  assign miss_inc  = miss_cnt_q + 4'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SEARCH;
      ref_q       <= 4'b0000;
      has_ref_q   <= 1'b0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      locked_o    <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= 8'd0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      has_ref_q   <= has_ref_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_o    <= locked_d;
      err_o       <= err_d;
      err_cnt_o   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    has_ref_d   = has_ref_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (valid_i) begin
      case (state_q)
        SEARCH: begin
          if (data_i == 4'b0000) begin
            has_ref_d   = 1'b0;
            match_cnt_d = 4'd0;
          end else if (!hit) begin
            ref_d       = data_i;
            has_ref_d   = 1'b1;
            match_cnt_d = 4'd0;
          end else begin
            ref_d       = data_i;
            match_cnt_d = match_inc;
            if (match_inc == SYNC_LEN_W) begin
              state_d    = LOCKED;
              miss_cnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          // Flywheel: the reference advances regardless of what arrived.
          ref_d = pred;
          if (hit) begin
            miss_cnt_d = 4'd0;
          end else begin
            miss_cnt_d = miss_inc;
            if (miss_inc == LOSS_LEN_W) begin
              state_d     = SEARCH;
              has_ref_d   = 1'b0;
              match_cnt_d = 4'd0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_d  = (state_d == LOCKED);
    err_d     = valid_i && (state_q == LOCKED) && !hit;
    err_cnt_d = err_cnt_o;
    if (clear_i)
      err_cnt_d = 8'd0;
    else if (err_d)
      err_cnt_d = sat_inc8(err_cnt_o);
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter SYNC_LEN, default 3: consecutive correct predictions needed to lock, legal range 1..15.
REQ-002 Parameter LOSS_LEN, default 2: consecutive mismatches while locked that force loss of lock, legal range 1..15.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  data_i carries a sample this cycle.
REQ-006 data_i  input  4  received value from a 4-bit x^4+x+1 generator, legal range 1..15.
REQ-007 clear_i  input  1  synchronous clear of err_cnt_o.
REQ-008 locked_o  output  1  checker is synchronised to the sequence.
REQ-009 err_o  output  1  one-cycle pulse flagging a mismatched sample while locked.
REQ-010 err_cnt_o  output  8  saturating count of locked-state mismatches.

Function
REQ-011 The prediction function SHALL be next(v) = {v[2:0], v[3]^v[0]}, replaced by 4'b1001 when that result is 4'b0000.
REQ-012 The block SHALL hold registers state (SEARCH/LOCKED), ref[3:0], has_ref, match_cnt[3:0] and miss_cnt[3:0].
REQ-013 All outputs SHALL be registered; each response appears in the cycle after the valid_i sample that caused it.
REQ-014 Cycles with valid_i=0 SHALL leave every register unchanged except for the effects of clear_i and the err_o return to 0.
REQ-015 A sample matches when has_ref=1, data_i != 0 and data_i == next(ref).
REQ-016 SEARCH, sample data_i=0: has_ref<=0, match_cnt<=0.
REQ-017 SEARCH, nonzero non-matching sample: ref<=data_i, has_ref<=1, match_cnt<=0.
REQ-018 SEARCH, matching sample: ref<=data_i, match_cnt<=match_cnt+1.
REQ-019 SEARCH, when the incremented match_cnt equals SYNC_LEN: state<=LOCKED, locked_o<=1, miss_cnt<=0.
REQ-020 LOCKED: ref SHALL advance as ref<=next(ref) on every valid sample regardless of data_i (flywheel), so one corrupted sample causes exactly one error.
REQ-021 LOCKED, match: miss_cnt<=0 and err_o stays 0.
REQ-022 LOCKED, mismatch (including data_i=0): err_o<=1 for one cycle, err_cnt_o<=err_cnt_o+1 saturating at 255, miss_cnt<=miss_cnt+1.
REQ-023 LOCKED, when the incremented miss_cnt equals LOSS_LEN: state<=SEARCH, locked_o<=0, has_ref<=0, match_cnt<=0; err_o and the err_cnt_o increment for that sample still occur.
REQ-024 err_cnt_o SHALL change only in LOCKED; mismatches in SEARCH are never counted.
REQ-025 clear_i=1 SHALL set err_cnt_o to 0 and SHALL take priority over a same-cycle increment; err_o still pulses for that sample.
REQ-026 err_cnt_o at 255 SHALL remain 255 on further mismatches; err_o still pulses.

Reset
REQ-027 rst_i=1 SHALL force state=SEARCH, ref=4'b0000, has_ref=0, match_cnt=0, miss_cnt=0, locked_o=0, err_o=0 and err_cnt_o=0 on the next edge, overriding valid_i and clear_i.
REQ-028 Reset asserted while locked SHALL drop locked_o to 0 on the next edge; the checker then needs SYNC_LEN+1 fresh samples to relock.

Verification
REQ-029 Lock (defaults): after reset, samples 1011, 0110, 1100, 1001 -> locked_o=1 the cycle after 1001, err_o never asserted.
REQ-030 Single error: while locked after 1001, samples 0111, 0100 -> err_o pulses once after 0111, err_cnt_o=1, locked_o remains 1, no error on 0100.
REQ-031 Loss: while locked, two consecutive wrong samples (0000, 1111) -> err_o pulses twice, err_cnt_o increases by 2, locked_o=0 after the second; then 0010, 0100, 1000, 0001 -> relock.
REQ-032 Gaps and clear: lock sequence with valid_i=0 idle cycles between samples -> same lock result; clear_i together with an error sample -> err_o=1, err_cnt_o=0.
REQ-033 Saturation: force 300 locked mismatches, keeping lock by alternating each bad sample with the correct one (LOSS_LEN=2) -> err_cnt_o=255.
REQ-034 Reset mid-lock: assert rst_i while locked with err_cnt_o=5 -> next cycle locked_o=0, err_cnt_o=0, err_o=0.
